// File: rtl/bus_arbiter.sv
// Bus frame sequencer: splits each 16-cycle frame into a video fetch phase and a CPU/bridge phase.
// Optional macro BUS_ARBITER_80COL_EN selects the 80-column double character fetch pattern.
module bus_arbiter #(
  parameter int FRAME_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       video_en,
  output logic       video_ram_strobe,
  output logic       video_rom_strobe,
  input  logic       cpu_rw,
  output logic       cpu_en,
  input  logic       bridge_req,
  input  logic       bridge_rw,
  output logic       bridge_ack,
  output logic       ram_oe,
  output logic       ram_we,
  output logic [1:0] addr_sel,
  output logic [3:0] slot_cycle
);

  typedef enum logic {
    OWN_CPU    = 1'b0,
    OWN_BRIDGE = 1'b1
  } owner_e;

  localparam logic [1:0] SEL_VIDEO  = 2'd0;
  localparam logic [1:0] SEL_CPU    = 2'd1;
  localparam logic [1:0] SEL_BRIDGE = 2'd2;
  localparam logic [1:0] SEL_IDLE   = 2'd3;

  logic [3:0] slot_cycle_q, slot_cycle_d;
  logic       vid_q, vid_d;
  owner_e     owner_q, owner_d;
  logic       rw_q, rw_d;
  logic       ram_strobe_q, ram_strobe_d;
  logic       rom_strobe_q, rom_strobe_d;
  logic       cpu_en_q, cpu_en_d;
  logic       bridge_ack_q, bridge_ack_d;
  logic       ram_oe_q, ram_oe_d;
  logic       ram_we_q, ram_we_d;
  logic [1:0] addr_sel_q, addr_sel_d;

  // Every output is computed for the cycle being entered (slot_cycle_d), so the
  // registered value lines up with slot_cycle in the same clock period.
  always_comb begin
    slot_cycle_d = slot_cycle_q + 4'd1;

    vid_d = vid_q;
    if (slot_cycle_q == 4'd15) begin
      vid_d = video_en;
    end

    owner_d = owner_q;
    rw_d    = rw_q;
    if (slot_cycle_q == 4'd7) begin
      if (bridge_req && (owner_q != OWN_BRIDGE)) begin
        owner_d = OWN_BRIDGE;
        rw_d    = bridge_rw;
      end else begin
        owner_d = OWN_CPU;
      end
    end
    if ((slot_cycle_q == 4'd8) && (owner_q == OWN_CPU)) begin
      rw_d = cpu_rw;
    end

    ram_strobe_d = 1'b0;
    rom_strobe_d = 1'b0;
    cpu_en_d     = 1'b0;
    bridge_ack_d = 1'b0;
    ram_oe_d     = 1'b0;
    ram_we_d     = 1'b0;
    addr_sel_d   = SEL_IDLE;

    if (!slot_cycle_d[3]) begin
      if (vid_d) begin
        addr_sel_d = SEL_VIDEO;
`ifdef BUS_ARBITER_80COL_EN
        ram_strobe_d = ~slot_cycle_d[1];
        rom_strobe_d = slot_cycle_d[1];
        ram_oe_d     = 1'b1;
`else
        ram_strobe_d = (slot_cycle_d[1:0] != 2'd0) && !slot_cycle_d[2];
        rom_strobe_d = (slot_cycle_d[1:0] != 2'd0) && slot_cycle_d[2];
        ram_oe_d     = (slot_cycle_d[1:0] != 2'd0);
`endif
      end
    end else begin
      addr_sel_d = (owner_d == OWN_BRIDGE) ? SEL_BRIDGE : SEL_CPU;
      if (slot_cycle_d != 4'd8) begin
        if (rw_d) begin
          ram_oe_d = 1'b1;
        end else if ((slot_cycle_d >= 4'd10) && (slot_cycle_d <= 4'd13)) begin
          ram_we_d = 1'b1;
        end
      end
      if (slot_cycle_d == 4'd15) begin
        if (owner_d == OWN_BRIDGE) begin
          bridge_ack_d = 1'b1;
        end else begin
          cpu_en_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cycle_q <= 4'd0;
      vid_q        <= 1'b0;
      owner_q      <= OWN_CPU;
      rw_q         <= 1'b1;
      ram_strobe_q <= 1'b0;
      rom_strobe_q <= 1'b0;
      cpu_en_q     <= 1'b0;
      bridge_ack_q <= 1'b0;
      ram_oe_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      addr_sel_q   <= SEL_IDLE;
    end else begin
      slot_cycle_q <= slot_cycle_d;
      vid_q        <= vid_d;
      owner_q      <= owner_d;
      rw_q         <= rw_d;
      ram_strobe_q <= ram_strobe_d;
      rom_strobe_q <= rom_strobe_d;
      cpu_en_q     <= cpu_en_d;
      bridge_ack_q <= bridge_ack_d;
      ram_oe_q     <= ram_oe_d;
      ram_we_q     <= ram_we_d;
      addr_sel_q   <= addr_sel_d;
    end
  end

  // Bus contention guard: the SRAM must never see OE and WE together.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(ram_oe_q && ram_we_q));
      assert (!ram_we_q || ((slot_cycle_q >= 4'd10) && (slot_cycle_q <= 4'd13)));
    end
  end

  assign slot_cycle       = slot_cycle_q;
  assign video_ram_strobe = ram_strobe_q;
  assign video_rom_strobe = rom_strobe_q;
  assign cpu_en           = cpu_en_q;
  assign bridge_ack       = bridge_ack_q;
  assign ram_oe           = ram_oe_q;
  assign ram_we           = ram_we_q;
  assign addr_sel         = addr_sel_q;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Time-slot sequencer for the shared 8-bit system SRAM and character ROM bus of the PET clone.
- Divides each 1 us bus frame (16 clk cycles at 16 MHz) into a video fetch phase and a CPU/bridge phase.
- Generates the video RAM/ROM fetch strobes consumed by the video generator, the 6502 clock enable, and the external MCU bridge grant.
- Drives SRAM output-enable, write-enable and address-mux select.

Parameters:
- FRAME_CYCLES, 16, clk cycles per bus frame; fixed at 16. The counter is 4 bits and the slot map below assumes 16.

Ports:
- clk  in  1  system clock, 16 MHz
- reset_n  in  1  asynchronous, active-low reset
- video_en  in  1  1 = perform video fetches this frame (sampled at cycle 15 for the next frame)
- video_ram_strobe  out  1  video RAM fetch strobe; video samples data on its falling edge
- video_rom_strobe  out  1  character ROM fetch strobe; falling edge samples data
- cpu_rw  in  1  6502 R/W for the current CPU cycle (1 = read)
- cpu_en  out  1  one-cycle 6502 clock-enable pulse
- bridge_req  in  1  MCU bridge access request, level, held until ack
- bridge_rw  in  1  bridge direction (1 = read)
- bridge_ack  out  1  one-cycle pulse; bridge access complete, read data valid this cycle
- ram_oe  out  1  SRAM/ROM output enable
- ram_we  out  1  SRAM write enable
- addr_sel  out  2  address mux: 0 video, 1 cpu, 2 bridge, 3 idle
- slot_cycle  out  4  current frame cycle counter (debug/scope)

Behaviour:
- All outputs are registered. On reset_n low, all of the following clear immediately (async), regardless of cycle position or any in-flight write:
  - slot_cycle = 0
  - both strobes, cpu_en, bridge_ack, ram_oe, ram_we = 0
  - addr_sel = 3
  - owner = CPU
  - alternation flag cleared
- First frame after reset release starts at cycle 0.
- slot_cycle increments every clk and wraps 15 -> 0.
- Video phase, cycles 0-7, only when the latched video_en = 1:
  - addr_sel = 0 for cycles 0-7.
  - video_ram_strobe = 1 in cycles 1-3.
  - video_rom_strobe = 1 in cycles 5-7.
  - ram_oe = 1 in cycles 1-3 and 5-7.
  - Each strobe's falling edge is at cycle 4 and cycle 8 respectively.
- Video phase with video_en = 0: cycles 0-7 idle (addr_sel = 3, strobes 0, ram_oe 0). The phase is not reassigned to the CPU.
- Owner decision at cycle 7 for cycles 8-15:
  - bridge_req = 1 and the previous slot was not bridge -> owner = BRIDGE.
  - otherwise owner = CPU.
  - Consecutive bridge slots are forbidden, so the CPU gets at least every other frame.
- CPU slot:
  - addr_sel = 1 for cycles 8-15.
  - Read: ram_oe = 1 for cycles 9-15.
  - Write: ram_we = 1 for cycles 10-13, ram_oe = 0.
  - cpu_en = 1 at cycle 15 only.
- Bridge slot:
  - addr_sel = 2 for cycles 8-15.
  - Same oe/we timing as the CPU slot, using bridge_rw.
  - bridge_ack = 1 at cycle 15.
  - cpu_en is not pulsed, so the CPU stalls for one frame.
- bridge_rw is sampled at cycle 7. cpu_rw is sampled at cycle 8.
- A requester that keeps bridge_req high after ack is served again no earlier than the frame after the next CPU slot.
- bridge_req dropped before cycle 7 means no grant. bridge_req dropped after cycle 7 does not cancel the slot.
- ram_oe and ram_we are never 1 together. ram_we is only ever asserted within cycles 10-13.

Optional Feature:
- Macro: BUS_ARBITER_80COL_EN.
- Defined (80-column mode): two character fetches per frame.
  - video_ram_strobe = 1 in cycles 0-1 and 4-5.
  - video_rom_strobe = 1 in cycles 2-3 and 6-7.
  - ram_oe = 1 in cycles 0-7.
  - CPU/bridge slot unchanged.
- Undefined: 40-column timing as in Behaviour.

Test Plan:
- Reset released, video_en = 1, no bridge -> video_ram_strobe high cycles 1-3, video_rom_strobe high cycles 5-7, cpu_en pulse at cycle 15, repeating every 16 clk.
- CPU write (cpu_rw = 0) -> addr_sel = 1 in cycles 8-15; ram_we high exactly cycles 10-13; ram_oe low throughout cycles 8-15.
- bridge_req held high for 4 frames -> owner sequence BRIDGE, CPU, BRIDGE, CPU; bridge_ack at cycle 15 of frames 0 and 2; cpu_en at cycle 15 of frames 1 and 3 only.
- video_en = 0 sampled at cycle 15 -> next frame: no strobes, addr_sel = 3 in cycles 0-7; CPU slot unchanged.
- reset_n asserted at cycle 11 of a write -> ram_we, addr_sel, slot_cycle clear immediately without waiting for a clk edge; after release, cycle 0 follows with owner = CPU.
- With BUS_ARBITER_80COL_EN defined -> strobe pattern RAM 0-1, ROM 2-3, RAM 4-5, ROM 6-7; four falling edges per frame.
